// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encodings and the
// per-entry control state kept in the history table.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_ALLOC = CTR_WT;
  localparam ctr_e CTR_RESET = CTR_WNT;

  // Tag and target widths depend on the top's parameters, so they live beside this.
  typedef struct packed {
    logic valid;
    ctr_e ctr;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter step used when training a table entry.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_e ctr,
  input  logic up,
  output ctr_e nxt
);

  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_ST) nxt = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) nxt = ctr_e'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB: combinational next-PC prediction in IF, training
// from resolved branches, mispredict flag and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_pc_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_pc_i,
  output logic             mispredict_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] lookup_cnt_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  bp_entry_t        meta_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [XLEN-1:0]  tgt_q  [DEPTH];
  logic [CNT_W-1:0] lookup_cnt_q, hit_cnt_q, mispred_cnt_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [XLEN-1:0]  up_exp_pc;
  ctr_e             ctr_next;
  logic             unused_pc_bits;

  assign lk_idx = if_pc_i[IDX_W+1:2];
  assign lk_tag = if_pc_i[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_hit       = meta_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o = lookup_valid_i && lk_hit &&
                        ((meta_q[lk_idx].ctr == CTR_WT) || (meta_q[lk_idx].ctr == CTR_ST));
  assign pred_pc_o    = pred_taken_o ? tgt_q[lk_idx] : if_pc_i + XLEN'(4);

  assign up_hit       = meta_q[up_idx].valid && (tag_q[up_idx] == up_tag);
  assign up_exp_pc    = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) || (up_exp_pc != upd_pred_pc_i));

  sat_counter2 u_ctr (
    .ctr (meta_q[up_idx].ctr),
    .up  (upd_taken_i),
    .nxt (ctr_next)
  );

  // Table write port; clear takes priority and drops a coincident update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '{valid: 1'b0, ctr: CTR_RESET};
        tag_q[i]  <= '0;
        tgt_q[i]  <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) meta_q[i].valid <= 1'b0;
    end else if (upd_valid_i) begin
      if (up_hit) begin
        meta_q[up_idx].ctr <= ctr_next;
        if (upd_taken_i) tgt_q[up_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        meta_q[up_idx] <= '{valid: 1'b1, ctr: CTR_ALLOC};
        tag_q[up_idx]  <= up_tag;
        tgt_q[up_idx]  <= upd_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lookup_cnt_q  <= '0;
      hit_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      lookup_cnt_q  <= sat_inc(lookup_cnt_q, lookup_valid_i);
      hit_cnt_q     <= sat_inc(hit_cnt_q, lookup_valid_i && lk_hit);
      mispred_cnt_q <= sat_inc(mispred_cnt_q, mispredict_o);
    end
  end

  assign lookup_cnt_o  = lookup_cnt_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, mid-cycle reset sequence,
// and randomized traffic checked against an array-based reference model.
module tb_branch_predictor;

  localparam int XLEN     = 32;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 8;
  localparam int DEPTH    = 16;
  localparam int STAT_MAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             lv = 1'b0;
  logic [31:0]      pc = '0;
  logic             uv = 1'b0;
  logic [31:0]      upc = '0;
  logic             ut = 1'b0;
  logic [31:0]      utgt = '0;
  logic             upt = 1'b0;
  logic [31:0]      uppc = '0;
  logic             clr = 1'b0;
  logic             pred_taken;
  logic [31:0]      pred_pc;
  logic             mispredict;
  logic [CNT_W-1:0] lookup_cnt, hit_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lookup_valid_i   (lv),
    .if_pc_i          (pc),
    .pred_taken_o     (pred_taken),
    .pred_pc_o        (pred_pc),
    .upd_valid_i      (uv),
    .upd_pc_i         (upc),
    .upd_taken_i      (ut),
    .upd_target_i     (utgt),
    .upd_pred_taken_i (upt),
    .upd_pred_pc_i    (uppc),
    .mispredict_o     (mispredict),
    .clear_i          (clr),
    .lookup_cnt_o     (lookup_cnt),
    .hit_cnt_o        (hit_cnt),
    .mispred_cnt_o    (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per table row, counter kept as a plain 0..3 integer.
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  int          m_lk, m_hit, m_mc;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (32'd4 * DEPTH);
  endfunction

  function automatic bit m_hits(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction

  function automatic bit m_taken(input logic [31:0] a);
    return m_hits(a) && (m_ctr[m_idx(a)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a);
    return m_taken(a) ? m_tgt[m_idx(a)] : a + 32'd4;
  endfunction

  function automatic bit m_mispred();
    logic [31:0] actual;
    actual = ut ? utgt : upc + 32'd4;
    return uv && ((ut != upt) || (actual != uppc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_lk = 0; m_hit = 0; m_mc = 0;
  endtask

  task automatic model_edge();
    bit lk_hit, up_hit, mp;
    int i;
    lk_hit = m_hits(pc);
    up_hit = m_hits(upc);
    mp     = m_mispred();
    if (lv && m_lk < STAT_MAX) m_lk++;
    if (lv && lk_hit && m_hit < STAT_MAX) m_hit++;
    if (mp && m_mc < STAT_MAX) m_mc++;
    i = m_idx(upc);
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (up_hit) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[i] = 1'b1; m_tag[i] = m_tagof(upc); m_tgt[i] = utgt; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    lv = 1'b0; pc = '0; uv = 1'b0; upc = '0; ut = 1'b0;
    utgt = '0; upt = 1'b0; uppc = '0; clr = 1'b0;
  endtask

  // Compare everything against the model mid-cycle, then advance the model at the edge.
  task automatic cycle_check(input string tag);
    bit e_tk; logic [31:0] e_pc;
    @(negedge clk);
    e_tk = lv && m_taken(pc);
    e_pc = e_tk ? m_tgt[m_idx(pc)] : pc + 32'd4;
    chk({tag, " pred_taken"}, 32'(pred_taken), 32'(e_tk));
    chk({tag, " pred_pc"}, pred_pc, e_pc);
    chk({tag, " mispredict"}, 32'(mispredict), 32'(m_mispred()));
    chk({tag, " lookup_cnt"}, 32'(lookup_cnt), 32'(m_lk));
    chk({tag, " hit_cnt"}, 32'(hit_cnt), 32'(m_hit));
    chk({tag, " mispred_cnt"}, 32'(mispred_cnt), 32'(m_mc));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        lv;  logic [31:0] pc;
    logic        uv;  logic [31:0] upc; logic ut; logic [31:0] utgt;
    logic        upt; logic [31:0] uppc; logic clr;
    logic        e_tk; logic [31:0] e_pc; logic e_mp;
    int          e_lk, e_hit, e_mc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic l, input logic [31:0] p, input logic u, input logic [31:0] up_pc,
                     input logic t, input logic [31:0] tg, input logic pt, input logic [31:0] ppc,
                     input logic c, input logic etk, input logic [31:0] epc, input logic emp,
                     input int elk, input int eh, input int emc);
    vec_t v;
    v.lv = l; v.pc = p; v.uv = u; v.upc = up_pc; v.ut = t; v.utgt = tg; v.upt = pt;
    v.uppc = ppc; v.clr = c; v.e_tk = etk; v.e_pc = epc; v.e_mp = emp;
    v.e_lk = elk; v.e_hit = eh; v.e_mc = emc;
    tbl.push_back(v);
  endtask

  initial begin
    // Directed sequence; expected stats are the values visible before each row's edge.
    add(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 0, 0, 0);
    add(1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h40,  1'b0, 32'h104, 1'b0, 1'b0, 32'h4,   1'b1, 1, 0, 0);
    add(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h40,  1'b0, 1, 0, 1);
    add(1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 1'b0, 32'h4,   1'b0, 2, 1, 1);
    add(1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 1'b0, 32'h4,   1'b0, 2, 1, 1);
    add(1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 1'b0, 32'h4,   1'b0, 2, 1, 1);
    add(1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h40,  1'b1, 32'h40,  1'b0, 1'b0, 32'h4,   1'b1, 2, 1, 1);
    add(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h40,  1'b1, 32'h40,  1'b0, 1'b1, 32'h40,  1'b1, 2, 1, 2);
    add(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 3, 2, 3);
    add(1'b0, 32'h0,   1'b1, 32'h140, 1'b1, 32'h80,  1'b0, 32'h144, 1'b0, 1'b0, 32'h4,   1'b1, 4, 3, 3);
    add(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 4, 3, 4);
    add(1'b1, 32'h140, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h80,  1'b0, 5, 3, 4);
    add(1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 32'h4,   1'b0, 6, 4, 4);
    add(1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 6, 4, 4);
    add(1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0, 7, 4, 4);
    add(1'b1, 32'h140, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h144, 1'b0, 8, 4, 4);
    add(1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 9, 4, 4);

    // Reset held from time 0: outputs at reset values, mispredict still combinational.
    model_reset();
    lv = 1'b1; pc = 32'h100; uv = 1'b1; upc = 32'h100; ut = 1'b1;
    utgt = 32'h40; upt = 1'b0; uppc = 32'h104;
    #2;
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    chk("reset pred_pc", pred_pc, 32'h104);
    chk("reset mispredict", 32'(mispredict), 32'd1);
    chk("reset lookup_cnt", 32'(lookup_cnt), 32'd0);
    chk("reset hit_cnt", 32'(hit_cnt), 32'd0);
    chk("reset mispred_cnt", 32'(mispred_cnt), 32'd0);
    idle();
    #10 rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[n]) begin
      lv = tbl[n].lv; pc = tbl[n].pc; uv = tbl[n].uv; upc = tbl[n].upc; ut = tbl[n].ut;
      utgt = tbl[n].utgt; upt = tbl[n].upt; uppc = tbl[n].uppc; clr = tbl[n].clr;
      @(negedge clk);
      chk($sformatf("vec%0d pred_taken", n), 32'(pred_taken), 32'(tbl[n].e_tk));
      chk($sformatf("vec%0d pred_pc", n), pred_pc, tbl[n].e_pc);
      chk($sformatf("vec%0d mispredict", n), 32'(mispredict), 32'(tbl[n].e_mp));
      chk($sformatf("vec%0d lookup_cnt", n), 32'(lookup_cnt), 32'(tbl[n].e_lk));
      chk($sformatf("vec%0d hit_cnt", n), 32'(hit_cnt), 32'(tbl[n].e_hit));
      chk($sformatf("vec%0d mispred_cnt", n), 32'(mispred_cnt), 32'(tbl[n].e_mc));
      @(posedge clk);
      model_edge();
      #1;
    end
    idle();

    // Install 0x100, then pulse reset low between edges.
    uv = 1'b1; upc = 32'h100; ut = 1'b1; utgt = 32'h40; upt = 1'b1; uppc = 32'h40;
    cycle_check("install");
    idle();
    lv = 1'b1; pc = 32'h100;
    @(negedge clk);
    chk("pre-reset pred_taken", 32'(pred_taken), 32'd1);
    chk("pre-reset pred_pc", pred_pc, 32'h40);
    uv = 1'b1; upc = 32'h100; ut = 1'b1; utgt = 32'h40; upt = 1'b0; uppc = 32'h104;
    #1 rst = 1'b0;
    #1;
    chk("midreset pred_taken", 32'(pred_taken), 32'd0);
    chk("midreset pred_pc", pred_pc, 32'h104);
    chk("midreset mispredict", 32'(mispredict), 32'd1);
    chk("midreset lookup_cnt", 32'(lookup_cnt), 32'd0);
    chk("midreset hit_cnt", 32'(hit_cnt), 32'd0);
    chk("midreset mispred_cnt", 32'(mispred_cnt), 32'd0);
    idle();
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    lv = 1'b1; pc = 32'h100;
    cycle_check("post-reset");
    idle();

    // Randomized traffic over a few aliasing PCs.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      lv  = ($urandom_range(0, 3) != 0);
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, DEPTH-1) << 2);
      uv  = ($urandom_range(0, 2) != 0);
      a   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, DEPTH-1) << 2);
      upc = a;
      ut  = 1'($urandom_range(0, 1));
      utgt = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 9) < 7) begin
        upt = m_taken(a); uppc = m_next(a);
      end else begin
        upt = 1'($urandom_range(0, 1)); uppc = 32'($urandom_range(0, 255)) << 2;
      end
      clr = ($urandom_range(0, 49) == 0);
      cycle_check($sformatf("rand%0d", n));
    end

    // Drive lookups until the statistics counters have to saturate.
    idle();
    for (int n = 0; n < 260; n++) begin
      lv = 1'b1; pc = 32'($urandom_range(0, 63)) << 2;
      cycle_check($sformatf("sat%0d", n));
    end
    idle();
    @(negedge clk);
    chk("lookup_cnt saturated", 32'(lookup_cnt), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch history table plus branch target buffer for the pipelined RISC-V CPU, parametrised in address width and table depth. It sits beside the PC in the IF stage and supplies a predicted next PC every cycle. It is trained from the ID-stage branch resolution, which today computes `branch && (RS1data == RS2data)`. It reports mispredicts so the CPU can flush IF/ID, and it keeps saturating lookup, hit and mispredict statistics.

## Interface
- `XLEN`, 32, PC/target width.
- `IDX_W`, 4, index bits; table has 2**IDX_W entries (legal 1..10).
- `CNT_W`, 32, statistics counter width.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset; one clock, asynchronous, active-low.
- `lookup_valid_i`  in  1  fetch PC is valid this cycle.
- `if_pc_i`  in  XLEN  fetch PC.
- `pred_taken_o`  out  1  predicted taken.
- `pred_pc_o`  out  XLEN  predicted next PC.
- `upd_valid_i`  in  1  a resolved branch is presented.
- `upd_pc_i`  in  XLEN  PC of resolved branch.
- `upd_taken_i`  in  1  actual outcome.
- `upd_target_i`  in  XLEN  actual taken target.
- `upd_pred_taken_i`  in  1  prediction made at fetch, carried down the pipe.
- `upd_pred_pc_i`  in  XLEN  predicted next PC carried down the pipe.
- `mispredict_o`  out  1  resolved branch was mispredicted.
- `clear_i`  in  1  synchronous invalidate of all entries, e.g. on fence.i.
- `lookup_cnt_o`, `hit_cnt_o`, `mispred_cnt_o`  out  CNT_W  statistics.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Lookup is combinational.
  - hit = valid & tag match.
  - pred_taken_o = lookup_valid_i & hit & ctr[1].
  - pred_pc_o = pred_taken_o ? target : if_pc_i+4. The +4 wraps modulo 2**XLEN.
- mispredict_o is combinational and equals upd_valid_i & ((upd_taken_i != upd_pred_taken_i) | (expected next PC != upd_pred_pc_i)).
  - Expected next PC = upd_taken_i ? upd_target_i : upd_pc_i+4.
- Update applies at the clock edge when upd_valid_i is high.
  - Hit, taken: counter increments, saturating at 11; target is rewritten with upd_target_i.
  - Hit, not taken: counter decrements, saturating at 00; target is kept.
  - Miss, taken: the entry is allocated or replaced; valid=1, tag written, target written, ctr=10.
  - Miss, not taken: no change.
- clear_i sets every valid bit to 0 on the next edge. Counters and targets are untouched. Statistics are untouched.
- clear_i and upd_valid_i in the same cycle: clear wins and the update is dropped.
- Statistics each increment by 1 per qualifying cycle and saturate at all-ones.
  - lookup_cnt: lookup_valid_i.
  - hit_cnt: lookup_valid_i & hit.
  - mispred_cnt: mispredict_o.

## Timing
- Lookup latency is 0 cycles. An update becomes visible to lookups from the cycle after its edge.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update state.
- Reset, asserted asynchronously at any time including mid-update, sets:
  - all valid=0, all ctr=01, all targets 0, all statistics 0;
  - pred_taken_o=0 and pred_pc_o=if_pc_i+4;
  - mispredict_o follows its inputs (combinational).
- Deassertion must be synchronised externally. The first update is accepted on the first rising edge after deassertion.
- No back-pressure. One lookup and one update per cycle, always accepted.

## Structure
- Package `bp_pkg` holds:
  - counter encodings CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11;
  - CTR_ALLOC=CTR_WT and CTR_RESET=CTR_WNT;
  - the entry struct/typedef.
- Sub-module `sat_counter2` implements the 2-bit saturating increment/decrement and is used in the update path.
- Table is a flop array (no SRAM), with one combinational read port for lookup and one for update hit-check, plus one write port.

## Test plan
- Reset then lookup pc=0x100 → pred_taken_o=0, pred_pc_o=0x104, lookup_cnt=1, hit_cnt=0.
- Update pc=0x100 taken target=0x40 with pred_taken=0, pred_pc=0x104 → mispredict_o=1, mispred_cnt=1. Next-cycle lookup 0x100 → taken, pred_pc_o=0x40, hit_cnt=1.
- Three further taken updates on 0x100 → ctr=11. Then two not-taken updates → ctr=01, so lookup 0x100 predicts not taken with pred_pc_o=0x104 and the entry is still valid (hit).
- Alias: with IDX_W=4, update taken on 0x140 (same index, different tag) → replaces the 0x100 entry. Lookup 0x100 then misses; lookup 0x140 hits.
- clear_i asserted together with a taken update on 0x200 → neither 0x100 nor 0x200 hits afterwards; statistics are unchanged.
- rst_i pulsed low mid-cycle between edges while entries are valid → outputs drop immediately to reset values. All statistics read 0 and no lookup hits after release.
